// File: rtl/rx_serial_7o1_if.sv
// Bus bundle for the 7O1 serial receiver: serial line and clear pulse in,
// received character, status flags and debug state code out.
interface rx_serial_7o1_if;
    logic       entrada_serial;
    logic       limpa;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_paridade;
    logic       erro_enquadramento;
    logic [3:0] db_estado;

    // Driver side (stimulus / host)
    modport master (
        output entrada_serial,
        output limpa,
        input  dados_ascii,
        input  pronto,
        input  tem_dado,
        input  erro_paridade,
        input  erro_enquadramento,
        input  db_estado
    );

    // Receiver side
    modport slave (
        input  entrada_serial,
        input  limpa,
        output dados_ascii,
        output pronto,
        output tem_dado,
        output erro_paridade,
        output erro_enquadramento,
        output db_estado
    );
endinterface

// File: rtl/rx_serial_7o1.sv
// Asynchronous serial receiver, 7O1 framing: start, 7 data bits LSB first,
// odd parity, one stop bit. Samples each bit at its middle using a tick
// counter restarted on every sample point.
module rx_serial_7o1 #(
    parameter int unsigned DIVISOR = 434,
    parameter int unsigned HALF    = DIVISOR / 2
) (
    input  logic           clock,
    input  logic           reset,
    rx_serial_7o1_if.slave bus
);
    localparam int unsigned CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        OCIOSO   = 4'd1,
        START    = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        PARADA   = 4'd5,
        FINAL    = 4'd6
    } state_t;

    state_t        state;
    logic [1:0]    sync;
    logic          rx;
    logic [CW-1:0] tick;
    logic [2:0]    nbit;
    logic [6:0]    shift;
    logic          par_bit;
    logic [6:0]    dados_q;
    logic          pronto_q;
    logic          tem_q;
    logic          pe_q;
    logic          fe_q;
    logic          half_hit;
    logic          full_hit;

    assign rx       = sync[1];
    assign half_hit = (tick == CW'(HALF - 1));
    assign full_hit = (tick == CW'(DIVISOR - 1));

    assign bus.dados_ascii        = dados_q;
    assign bus.pronto             = pronto_q;
    assign bus.tem_dado           = tem_q;
    assign bus.erro_paridade      = pe_q;
    assign bus.erro_enquadramento = fe_q;
    assign bus.db_estado          = 4'(state);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], bus.entrada_serial};
        end
    end

    // Receive FSM with tick counter, shift register and result registers.
    // Results are loaded on the edge entering FINAL so they are visible
    // (with pronto high) for exactly the FINAL cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= INICIAL;
            tick     <= '0;
            nbit     <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            dados_q  <= '0;
            pronto_q <= 1'b0;
            tem_q    <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            tick     <= tick + CW'(1);
            // A clear during FINAL loses to the frame that just completed.
            if (bus.limpa && state != FINAL) begin
                tem_q <= 1'b0;
            end
            case (state)
                INICIAL: begin
                    if (rx) begin
                        state <= OCIOSO;
                    end
                end
                OCIOSO: begin
                    tick <= '0;
                    if (!rx) begin
                        state <= START;
                    end
                end
                START: begin
                    if (half_hit) begin
                        tick <= '0;
                        nbit <= '0;
                        state <= rx ? OCIOSO : DADOS;
                    end
                end
                DADOS: begin
                    if (full_hit) begin
                        tick  <= '0;
                        shift <= {rx, shift[6:1]};
                        nbit  <= nbit + 3'd1;
                        if (nbit == 3'd6) begin
                            state <= PARIDADE;
                        end
                    end
                end
                PARIDADE: begin
                    if (full_hit) begin
                        tick    <= '0;
                        par_bit <= rx;
                        state   <= PARADA;
                    end
                end
                PARADA: begin
                    if (full_hit) begin
                        tick     <= '0;
                        dados_q  <= shift;
                        pe_q     <= ~((^shift) ^ par_bit);
                        fe_q     <= ~rx;
                        tem_q    <= 1'b1;
                        pronto_q <= 1'b1;
                        state    <= FINAL;
                    end
                end
                FINAL: begin
                    state <= INICIAL;
                end
                default: begin
                    state <= INICIAL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1: frames are generated bit by bit with a chosen
// sender rate; expected characters/flags go into a queue and a monitor
// compares them whenever pronto is seen.
module tb_rx_serial_7o1;
    localparam int unsigned DIV = 48;
    localparam int unsigned HLF = DIV / 2;

    typedef struct {
        logic [6:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t       q[$];
    int         total    = 0;
    int         bad      = 0;
    int         npush    = 0;
    int         npronto  = 0;
    int         fin_req  = 0;
    int         fin_done = 0;
    int         now_req  = 0;
    int         now_done = 0;
    logic [6:0] model_d  = 7'd0;

    rx_serial_7o1_if bus();

    rx_serial_7o1 #(.DIVISOR(DIV), .HALF(HLF)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Serial frame generator; rate is in per-mille of nominal bit length.
    task automatic send_frame(input logic [6:0] d, input logic par, input logic stp,
                              input int rate, input bit push);
        logic [9:0] bits;
        int         elapsed;
        int         target;
        exp_t       e;
        bits = {stp, par, d, 1'b0};
        if (push) begin
            e.d  = d;
            e.pe = ((($countones(d) + int'(par)) % 2) == 0);
            e.fe = (stp == 1'b0);
            q.push_back(e);
            npush++;
        end
        elapsed = 0;
        for (int i = 0; i < 10; i++) begin
            bus.entrada_serial = bits[i];
            target = ((i + 1) * int'(DIV) * rate + 500) / 1000;
            while (elapsed < target) begin
                @(posedge clk);
                #1;
                elapsed++;
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40 * int'(DIV)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size(), 0);
    endtask

    function automatic logic good_par(input logic [6:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    // Scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.pronto) begin
                npronto++;
                if (q.size() == 0) begin
                    check("unexpected pronto", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("dados_ascii", int'(bus.dados_ascii), int'(e.d));
                    check("erro_paridade", int'(bus.erro_paridade), int'(e.pe));
                    check("erro_enquadramento", int'(bus.erro_enquadramento), int'(e.fe));
                    check("tem_dado at pronto", int'(bus.tem_dado), 1);
                    model_d = e.d;
                end
            end
        end
    end

    // limpa driver: either coincident with pronto, or immediately
    initial begin
        bus.limpa = 1'b0;
        forever begin
            @(negedge clk);
            if (fin_req != fin_done && bus.pronto) begin
                bus.limpa = 1'b1;
                fin_done++;
            end else if (now_req != now_done) begin
                bus.limpa = 1'b1;
                now_done++;
            end else begin
                bus.limpa = 1'b0;
            end
        end
    end

    initial begin
        logic [6:0] d;
        logic       p;
        logic       s;
        int         rate;

        rst = 1'b1;
        bus.entrada_serial = 1'b1;
        cycles(3);
        @(negedge clk);
        check("rst dados", int'(bus.dados_ascii), 0);
        check("rst pronto", int'(bus.pronto), 0);
        check("rst tem_dado", int'(bus.tem_dado), 0);
        check("rst erro_par", int'(bus.erro_paridade), 0);
        check("rst erro_enq", int'(bus.erro_enquadramento), 0);
        check("rst estado", int'(bus.db_estado), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycles(4);
        @(negedge clk);
        check("idle estado", int'(bus.db_estado), 1);

        // 'A', then 'A' and '#' back to back
        send_frame(7'h41, 1'b1, 1'b1, 1000, 1'b1);
        cycles(int'(DIV));
        wait_drain();
        send_frame(7'h41, 1'b1, 1'b1, 1000, 1'b1);
        send_frame(7'h23, 1'b0, 1'b1, 1000, 1'b1);
        cycles(int'(DIV));
        wait_drain();

        // Bad parity, then stop 0 followed by a long break
        send_frame(7'h23, 1'b1, 1'b1, 1000, 1'b1);
        cycles(int'(DIV));
        send_frame(7'h2a, good_par(7'h2a), 1'b0, 1000, 1'b1);
        cycles(30 * int'(DIV));
        bus.entrada_serial = 1'b1;
        cycles(2 * int'(DIV));
        wait_drain();
        check("break single frame", npronto, npush);

        // Short low glitch on idle line
        bus.entrada_serial = 1'b0;
        cycles(5);
        @(negedge clk);
        check("glitch start estado", int'(bus.db_estado), 2);
        cycles(int'(DIV) * 3 / 10 - 5);
        bus.entrada_serial = 1'b1;
        cycles(int'(DIV));
        @(negedge clk);
        check("glitch estado", int'(bus.db_estado), 1);
        check("glitch dados", int'(bus.dados_ascii), int'(model_d));
        check("glitch pronto count", npronto, npush);

        // Reset in the middle of data bit 3 of '5' (0110101)
        bus.entrada_serial = 1'b0; cycles(int'(DIV));
        bus.entrada_serial = 1'b1; cycles(int'(DIV));
        bus.entrada_serial = 1'b0; cycles(int'(DIV));
        bus.entrada_serial = 1'b1; cycles(int'(DIV));
        bus.entrada_serial = 1'b0; cycles(int'(HLF));
        @(negedge clk);
        check("mid frame estado", int'(bus.db_estado), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.entrada_serial = 1'b1;
        @(negedge clk);
        check("mrst dados", int'(bus.dados_ascii), 0);
        check("mrst tem_dado", int'(bus.tem_dado), 0);
        check("mrst erro_par", int'(bus.erro_paridade), 0);
        check("mrst erro_enq", int'(bus.erro_enquadramento), 0);
        check("mrst estado", int'(bus.db_estado), 0);
        cycles(2 * int'(DIV));
        send_frame(7'h35, good_par(7'h35), 1'b1, 1000, 1'b1);
        cycles(int'(DIV));
        wait_drain();

        // limpa coincident with FINAL, then limpa on its own
        fin_req++;
        send_frame(7'h4d, good_par(7'h4d), 1'b1, 1000, 1'b1);
        cycles(int'(DIV));
        wait_drain();
        check("limpa at final issued", fin_done, fin_req);
        @(negedge clk);
        check("tem_dado after limpa at final", int'(bus.tem_dado), 1);
        cycles(10);
        now_req++;
        cycles(3);
        @(negedge clk);
        check("tem_dado after limpa", int'(bus.tem_dado), 0);

        // Sender 3% slow
        send_frame(7'h5a, good_par(7'h5a), 1'b1, 1030, 1'b1);
        cycles(int'(DIV));
        wait_drain();

        // Randomized frames
        for (int i = 0; i < 20; i++) begin
            d    = 7'($urandom_range(0, 127));
            p    = good_par(d) ^ ($urandom_range(0, 4) == 0);
            s    = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
            rate = ($urandom_range(0, 1) == 1) ? 1030 : 1000;
            send_frame(d, p, s, rate, 1'b1);
            bus.entrada_serial = 1'b1;
            if (s == 1'b0 || $urandom_range(0, 1) == 1) begin
                cycles(int'(DIV));
            end
        end
        cycles(int'(DIV));
        wait_drain();
        check("queue empty", q.size(), 0);
        check("pronto count", npronto, npush);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
